// File: rtl/uart_pkg.sv
// Package: uart_pkg
// Purpose: shared definitions for the uart_tx_arbiter block. These are the
//          arbiter FSM state encodings (one-hot) and the UART data width.
// Ports:   none (package)
// Config:  no macros are used in this file. UART_TX_ARB_LOCK_EN affects only uart_tx_arbiter.sv.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // One-hot state encoding. Each state is a single flop, so checkers can
    // test for one state with one bit.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'b001,
        ST_ISSUE     = 3'b010,
        ST_WAIT_DONE = 3'b100
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Module: rr_pick
// Purpose: combinational round-robin picker. It returns the first asserted
//          request, searching upward from ptr+1 and wrapping at N.
// Ports:
//   req  in  N      request vector
//   ptr  in  IDX_W  index of the most recent winner
//   gnt  out N      one-hot winner, all zero when no request
//   idx  out IDX_W  winner index, zero when no request
//   any  out 1      at least one request is asserted
// Config:  no macros.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // The search visits ptr+1 ... ptr+N with wrap. The previous winner is visited last.
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Module: uart_tx_arbiter
// Purpose: shares one uart_tx transmitter between N_REQ byte producers.
//          Arbitration is round-robin. Each accepted byte gives exactly one tx_stb_o pulse.
//          The arbiter then waits for tx_done_i before it accepts another byte.
//          The block holds no FIFO.
// Ports:
//   clk_i        in   1          clock
//   rst_i        in   1          asynchronous active-high reset
//   req_valid_i  in   N_REQ      requester r has a byte
//   req_data_i   in   8*N_REQ    byte of requester r at [8r+7:8r]
//   req_last_i   in   N_REQ      last byte of a message (lock build only)
//   req_ready_o  out  N_REQ      one-hot accept, combinational in IDLE
//   tx_stb_o     out  1          one-cycle strobe to uart_tx
//   tx_data_o    out  8          byte to uart_tx, stable until the next accept
//   tx_busy_i    in   1          uart_tx busy
//   tx_done_i    in   1          uart_tx done pulse
//   grant_o      out  N_REQ      one-hot owner of the byte in flight
//   active_o     out  1          a byte is in flight
// Config: define UART_TX_ARB_LOCK_EN to enable message lock. While a message
//         from one requester is unfinished (req_last_i=0 on its last accepted
//         byte), arbitration considers only that requester.
//
// Handshake: a byte from requester r is transferred in the cycle where
// req_valid_i[r] & req_ready_o[r] is high. Ready is asserted only in IDLE,
// only while tx_busy_i is low, and only for the round-robin winner. A
// requester can drop valid at any time before that cycle with no effect.
// Data only needs to be stable in the transfer cycle.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    input  logic [UART_DATA_W*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]             req_last_i,
    output logic [N_REQ-1:0]             req_ready_o,
    output logic                         tx_stb_o,
    output logic [UART_DATA_W-1:0]       tx_data_o,
    input  logic                         tx_busy_i,
    input  logic                         tx_done_i,
    output logic [N_REQ-1:0]             grant_o,
    output logic                         active_o
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t                 state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [UART_DATA_W-1:0] data_q;
    logic [N_REQ-1:0]       grant_q;
    logic                   stb_q;
    logic                   active_q;

    logic [N_REQ-1:0]       elig;
    logic [N_REQ-1:0]       pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   accept;

`ifdef UART_TX_ARB_LOCK_EN
    logic                   lock_q;
    logic [IDX_W-1:0]       lock_idx_q;

    // While locked, only the lock owner may compete.
    always_comb begin
        elig = req_valid_i;
        if (lock_q) begin
            elig = req_valid_i & ({{(N_REQ-1){1'b0}}, 1'b1} << lock_idx_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (accept) begin
            lock_q     <= ~req_last_i[pick_idx];
            lock_idx_q <= pick_idx;
        end
    end
`else
    logic unused_last;

    assign elig        = req_valid_i;
    assign unused_last = ^req_last_i;
`endif

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (elig),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // An accept needs IDLE and an idle transmitter. Ready is gated with the
    // reset input so it reads 0 while reset is held.
    assign accept      = (state_q == ST_IDLE) && !tx_busy_i && pick_any && !rst_i;
    assign req_ready_o = accept ? pick_gnt : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IDX_W'(N_REQ - 1);
            data_q   <= '0;
            grant_q  <= '0;
            stb_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q   <= req_data_i[{pick_idx, 3'b000} +: UART_DATA_W];
                        grant_q  <= pick_gnt;
                        ptr_q    <= pick_idx;
                        stb_q    <= 1'b1;
                        active_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    stb_q   <= 1'b0;
                    state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done_i) begin
                        grant_q  <= '0;
                        active_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    stb_q    <= 1'b0;
                    grant_q  <= '0;
                    active_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_stb_o  = stb_q;
    assign tx_data_o = data_q;
    assign grant_o   = grant_q;
    assign active_o  = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (N_REQ=4). It compiles against either build
// of UART_TX_ARB_LOCK_EN. The reference model tracks only a few quantities:
// the last winner, the lock owner, whether a byte is in flight, and a queue
// of expected strobe bytes.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk_i;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_ready_o;
  logic           tx_stb_o;
  logic [7:0]     tx_data_o;
  logic           tx_busy_i;
  logic           tx_done_i;
  logic [N-1:0]   grant_o;
  logic           active_o;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_stb_o    (tx_stb_o),
    .tx_data_o   (tx_data_o),
    .tx_busy_i   (tx_busy_i),
    .tx_done_i   (tx_done_i),
    .grant_o     (grant_o),
    .active_o    (active_o)
  );

  // ---------------- clock ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- counters ----------------
  int checks = 0;
  int errors = 0;

  // ---------------- reference model state ----------------
  bit         m_inflight;
  bit         m_stb;
  int         m_owner;
  int         m_last;
  int         m_lock;
  logic [7:0] m_data;
  logic [7:0] exp_q[$];
  logic [7:0] stb_log[$];

  // transmitter stand-in
  int tx_rem    = 0;
  int hold_busy = 0;
  int frame_len = 5;
  bit spurious  = 0;

  // snapshot of the last sampled cycle
  logic [N-1:0] obs_ready;
  logic         obs_stb;
  logic [7:0]   obs_data;
  int           acc_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int r = (m_last + k) % N;
      if (req_valid_i[r] && (m_lock < 0 || m_lock == r)) return r;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int r = 0; r < N; r++) if (v == (4'b0001 << r)) return r;
    return -1;
  endfunction

  // One clock cycle. It is entered at a negedge after the requester inputs are set.
  // It drives the transmitter inputs, checks every output against the model,
  // advances the model, and returns at the next negedge.
  task automatic step();
    int         w;
    logic [3:0] er;
    logic [7:0] d;
    tx_done_i = 1'b0;
    if (tx_rem > 0) begin
      tx_rem--;
      if (tx_rem == 0) tx_done_i = 1'b1;
    end else if (spurious && $urandom_range(0, 7) == 0) begin
      tx_done_i = 1'b1;
    end
    tx_busy_i = (tx_rem > 0) || (hold_busy > 0);
    if (hold_busy > 0) hold_busy--;
    #1;
    w  = (!m_inflight && !tx_busy_i) ? pick() : -1;
    er = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    obs_ready = req_ready_o;
    obs_stb   = tx_stb_o;
    obs_data  = tx_data_o;
    chk("ready", req_ready_o, er);
    chk("stb", tx_stb_o, m_stb);
    chk("data", tx_data_o, m_data);
    chk("grant", grant_o, (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000);
    chk("active", active_o, m_inflight);
    if (tx_stb_o === 1'b1) begin
      stb_log.push_back(tx_data_o);
      if (exp_q.size() == 0) chk("sb_extra_stb", tx_stb_o, 1'b0);
      else begin
        d = exp_q.pop_front();
        chk("sb_data", tx_data_o, d);
      end
    end
    if (m_stb) tx_rem = (frame_len > 0) ? frame_len : $urandom_range(2, 7);
    acc_idx = w;
    if (w >= 0) begin
      m_inflight = 1'b1;
      m_stb      = 1'b1;
      m_owner    = w;
      m_data     = req_data_i[8*w +: 8];
      m_last     = w;
      exp_q.push_back(m_data);
`ifdef UART_TX_ARB_LOCK_EN
      m_lock = req_last_i[w] ? -1 : w;
`endif
    end else if (m_stb) begin
      m_stb = 1'b0;
    end else if (m_inflight && tx_done_i) begin
      m_inflight = 1'b0;
      m_owner    = -1;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset(input int cycles);
    rst_i = 1'b1;
    #1;
    chk("rst_ready", req_ready_o, 4'b0000);
    chk("rst_stb", tx_stb_o, 1'b0);
    chk("rst_data", tx_data_o, 8'h00);
    chk("rst_grant", grant_o, 4'b0000);
    chk("rst_active", active_o, 1'b0);
    m_inflight = 1'b0;
    m_stb      = 1'b0;
    m_owner    = -1;
    m_last     = N - 1;
    m_lock     = -1;
    m_data     = 8'h00;
    exp_q.delete();
    stb_log.delete();
    repeat (cycles) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_accept(input int bound, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      step();
      if (acc_idx >= 0) got = 1'b1;
    end
    chk(tag, got, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && m_inflight; i++) step();
    chk("drain_idle", active_o, 1'b0);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int         order[4];
    int         exp_order[4];
    int         n;
    int         k1;
    logic [7:0] exp_seq[5];

    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    tx_busy_i   = 1'b0;
    tx_done_i   = 1'b0;
    @(negedge clk_i);

    // 1: single requester 2, accept-to-strobe latency, single strobe
    frame_len = 5;
    do_reset(2);
    req_data_i = $urandom;
    req_data_i[23:16] = 8'h55;
    req_valid_i = 4'b0100;
    step();
    chk("t1_ready", obs_ready, 4'b0100);
    req_valid_i = 4'b0000;
    step();
    chk("t1_stb", obs_stb, 1'b1);
    chk("t1_data", obs_data, 8'h55);
    drain();
    repeat (3) step();
    chk("t1_stb_count", stb_log.size(), 1);

    // 2: all four valid, strobe order A0 A1 A2 A3 A0
    do_reset(1);
    req_data_i  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_last_i  = 4'b1111;
    req_valid_i = 4'b1111;
    for (int i = 0; i < 200 && stb_log.size() < 5; i++) step();
    chk("t2_count", (stb_log.size() >= 5), 1'b1);
    exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    for (int i = 0; i < 5; i++)
      if (i < stb_log.size()) chk($sformatf("t2_seq%0d", i), stb_log[i], exp_seq[i]);
    req_valid_i = 4'b0000;
    drain();

    // 3: transmitter busy across reset blocks accepts
    do_reset(2);
    hold_busy   = 20;
    req_data_i[7:0] = 8'h3C;
    req_valid_i = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t3_blocked_ready", obs_ready, 4'b0000);
      chk("t3_blocked_stb", obs_stb, 1'b0);
    end
    step();
    chk("t3_accept", obs_ready, 4'b0001);
    req_valid_i = 4'b0000;
    step();
    chk("t3_stb", obs_stb, 1'b1);
    chk("t3_data", obs_data, 8'h3C);
    drain();

    // 4: reset while waiting for done with owner 2, then all valid
    do_reset(1);
    req_data_i  = {8'hD3, 8'hD2, 8'h44, 8'hD0};
    req_valid_i = 4'b0100;
    step();
    chk("t4_owner", obs_ready, 4'b0100);
    req_valid_i = 4'b0000;
    step();
    step();
    chk("t4_in_wait_grant", grant_o, 4'b0100);
    req_valid_i = 4'b1111;
    do_reset(1);
    n = 0;
    for (int i = 0; i < 40 && n == 0; i++) begin
      step();
      if (obs_ready != 4'b0000) n = 1;
    end
    chk("t4_first_grant", obs_ready, 4'b0001);
    req_valid_i = 4'b0000;
    step();
    chk("t4_first_data", obs_data, 8'hD0);
    drain();

    // 5: requester 1 sends a 3-byte message while requester 0 stays valid
    do_reset(1);
    frame_len   = 3;
    req_data_i  = '0;
    req_data_i[7:0] = 8'h0F;
    req_last_i  = 4'b0001;
    req_valid_i = 4'b0001;
    wait_accept(20, "t5_pre_accept");
    req_data_i[15:8] = 8'h11;
    req_valid_i = 4'b0011;
    k1 = 0;
    n  = 0;
    order = '{-1, -1, -1, -1};
    for (int i = 0; i < 300 && n < 4; i++) begin
      step();
      if (obs_ready != 4'b0000) begin
        order[n] = onehot_idx(obs_ready);
        n++;
        if (obs_ready[1]) begin
          k1++;
          req_data_i[15:8] = 8'(8'h11 + k1);
          req_last_i[1]    = (k1 == 2);
          if (k1 == 3) req_valid_i[1] = 1'b0;
        end
      end
    end
    chk("t5_count", n, 4);
`ifdef UART_TX_ARB_LOCK_EN
    exp_order = '{1, 1, 1, 0};
`else
    exp_order = '{1, 0, 1, 0};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("t5_order%0d", i), order[i], exp_order[i]);
    req_valid_i = 4'b0000;
    drain();

    // 6: short-lived valid from requester 3 during WAIT_DONE is not taken
    do_reset(1);
    frame_len   = 5;
    req_data_i  = {8'h33, 8'h00, 8'h00, 8'h01};
    req_last_i  = 4'b1111;
    req_valid_i = 4'b0001;
    wait_accept(20, "t6_accept");
    req_valid_i = 4'b0000;
    step();
    req_valid_i = 4'b1000;
    step();
    chk("t6_ready", obs_ready, 4'b0000);
    req_valid_i = 4'b0000;
    drain();
    repeat (4) step();
    chk("t6_stb_count", stb_log.size(), 1);
    if (stb_log.size() > 0) chk("t6_stb_data", stb_log[0], 8'h01);

    // random traffic with random frame lengths, busy bursts and stray done pulses
    do_reset(1);
    frame_len = 0;
    spurious  = 1'b1;
    for (int i = 0; i < 800; i++) begin
      req_valid_i = 4'($urandom | $urandom);
      req_data_i  = $urandom;
      req_last_i  = 4'($urandom);
      if ($urandom_range(0, 40) == 0) hold_busy = $urandom_range(1, 4);
      step();
    end
    spurious    = 1'b0;
    req_valid_i = 4'b0000;
    drain();
    repeat (10) step();
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
